step_player: RTL and testbench
==============================

STEP_PLAYER -- requirements
Module: step_player

Interface
REQ-001 SHALL have parameter TRACKS, default 4, number of trigger tracks.
REQ-002 SHALL have parameter STEPS, default 16, pattern steps per track.
REQ-003 SHALL have parameter GATE_W, default 8, width of gate-length counter.
REQ-004 SHALL have port Clock  in  1  system clock, all state on rising edge.
REQ-005 SHALL have port nReset  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port Step  in  1  one-cycle tempo pulse from upstream BPM counter.
REQ-007 SHALL have port Play  in  1  level; 1 = run, 0 = stop.
REQ-008 SHALL have port Clear  in  1  one-cycle pulse, erase whole pattern.
REQ-009 SHALL have port WrEn  in  1  pattern write strobe.
REQ-010 SHALL have port WrTrack  in  2  track index for write.
REQ-011 SHALL have port WrStep  in  4  step index for write.
REQ-012 SHALL have port WrData  in  1  bit value written.
REQ-013 SHALL have port Length  in  5  active loop length in steps.
REQ-014 SHALL have port GateLen  in  GATE_W  trigger high time in Clock cycles.
REQ-015 SHALL have port CurStep  out  4  index of last fired step.
REQ-016 SHALL have port Trig  out  TRACKS  per-track trigger outputs.
REQ-017 SHALL have port Running  out  1  high while in PLAY state.
REQ-018 SHALL have port Beat  out  1  one-cycle pulse when step 0 fires.

Function
REQ-019 SHALL hold pattern as TRACKS x STEPS bit array plus next-step pointer Ptr (4 bits).
REQ-020 SHALL implement two states: IDLE, PLAY; IDLE->PLAY when Play=1, PLAY->IDLE when Play=0, transition on next Clock edge.
REQ-021 SHALL, in IDLE: Ptr=0, Trig=0, Beat=0, CurStep=0, Step ignored.
REQ-022 SHALL, on Step=1 in PLAY: Trig<=pattern[*][Ptr], CurStep<=Ptr, gate counter<=GateLen, Beat<=(Ptr==0); outputs visible one Clock after Step.
REQ-023 SHALL advance Ptr<=Ptr+1 on each fired step, wrapping to 0 when Ptr+1 >= effective length.
REQ-024 SHALL use effective length = Length for 1..16; Length 0 or >16 treated as 16.
REQ-025 SHALL wrap Ptr to 0 at next Step if Length is reduced mid-play to <= Ptr (step 0 fires, Beat=1).
REQ-026 SHALL hold Trig while gate counter nonzero, decrement counter each cycle, clear Trig when it reaches 0; GateLen=0 treated as 1.
REQ-027 SHALL, on Step during active gate, retrigger: replace Trig with new column and reload counter (no gap cycle).
REQ-028 SHALL drive Beat for exactly one cycle per step-0 firing, independent of gate.
REQ-029 SHALL write pattern[WrTrack][WrStep]<=WrData on WrEn in any state; WrTrack >= TRACKS ignored.
REQ-030 SHALL, when write and Step target same cell in same cycle, fire old value; new value used on next visit.
REQ-031 SHALL zero all pattern bits on Clear in one cycle; Clear has priority over simultaneous WrEn.
REQ-032 SHALL, on Play falling to 0 mid-gate, clear Trig and counter on the transition edge.
REQ-033 SHALL drive Running=1 exactly in PLAY.

Reset
REQ-034 SHALL, on nReset=0, asynchronously set state=IDLE, Ptr=0, CurStep=0, Trig=0, Beat=0, Running=0, gate counter=0, all pattern bits 0.
REQ-035 SHALL leave reset synchronously on first Clock edge after nReset rises; reset mid-gate drops Trig immediately.

Verification
REQ-036 Write track0 steps 0,4,8,12=1, Length=16, GateLen=3, Play=1, 16 Step pulses 100 cycles apart -> Trig[0] high 3 cycles on steps 0,4,8,12 only, Beat once at step 0.
REQ-037 Length=3, 7 Step pulses -> CurStep sequence 0,1,2,0,1,2,0, Beat on pulses 1,4,7.
REQ-038 GateLen=10, Step pulses 4 cycles apart, all pattern bits 1 -> Trig[3:0] continuously 4'hF, no low cycle between steps.
REQ-039 WrEn writing track1 step2=1 same cycle Step fires step 2 with old value 0 -> Trig[1]=0 this pass, 1 on next loop; Clear with WrEn same cycle -> pattern all 0.
REQ-040 Play=0 mid-gate -> Trig=0, Running=0 next edge; Play=1 again -> next Step fires step 0; nReset pulse mid-gate -> Trig=0 without Clock edge.

Source files
------------

// File: rtl/step_player.sv
// Multi-track step sequencer: plays a TRACKS x STEPS trigger pattern on each
// tempo pulse, with per-step gate length, loop length control and live editing.
module step_player #(
    parameter int TRACKS = 4,
    parameter int STEPS  = 16,
    parameter int GATE_W = 8
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Step,
    input  logic              Play,
    input  logic              Clear,
    input  logic              WrEn,
    input  logic [1:0]        WrTrack,
    input  logic [3:0]        WrStep,
    input  logic              WrData,
    input  logic [4:0]        Length,
    input  logic [GATE_W-1:0] GateLen,
    output logic [3:0]        CurStep,
    output logic [TRACKS-1:0] Trig,
    output logic              Running,
    output logic              Beat
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [4:0]        MAX_LEN  = 5'(STEPS);
    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [3:0]               ptr_q, ptr_d;
    logic [3:0]               cur_step_q, cur_step_d;
    logic [TRACKS-1:0]        trig_q, trig_d;
    logic [GATE_W-1:0]        gate_q, gate_d;
    logic                     beat_q, beat_d;
    logic                     running_q, running_d;
    logic [TRACKS-1:0][STEPS-1:0] pattern_q, pattern_d;

    logic [4:0]               eff_len;
    logic [3:0]               fire_idx;
    logic [4:0]               next_idx;
    logic [GATE_W-1:0]        gate_load;
    logic [TRACKS-1:0]        column;

    // A pointer left beyond a freshly shortened loop restarts the loop at step 0.
    always_comb begin
        eff_len   = (Length == 5'd0 || Length > MAX_LEN) ? MAX_LEN : Length;
        fire_idx  = ({1'b0, ptr_q} >= eff_len) ? 4'd0 : ptr_q;
        next_idx  = {1'b0, fire_idx} + 5'd1;
        gate_load = (GateLen == '0) ? GATE_ONE : GateLen;
        for (int t = 0; t < TRACKS; t++) begin
            column[t] = pattern_q[t][fire_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_step_d = cur_step_q;
        trig_d     = trig_q;
        gate_d     = gate_q;
        beat_d     = 1'b0;
        case (state_q)
            IDLE: begin
                ptr_d      = '0;
                cur_step_d = '0;
                trig_d     = '0;
                gate_d     = '0;
                if (Play) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (!Play) begin
                    state_d    = IDLE;
                    ptr_d      = '0;
                    cur_step_d = '0;
                    trig_d     = '0;
                    gate_d     = '0;
                end else if (Step) begin
                    // A step during an open gate simply overwrites it: no gap cycle.
                    trig_d     = column;
                    cur_step_d = fire_idx;
                    gate_d     = gate_load;
                    beat_d     = (fire_idx == 4'd0);
                    ptr_d      = (next_idx >= eff_len) ? 4'd0 : next_idx[3:0];
                end else if (gate_q != '0) begin
                    gate_d = gate_q - GATE_ONE;
                    if (gate_q == GATE_ONE) begin
                        trig_d = '0;
                    end
                end
            end
        endcase
        running_d = (state_d == PLAY);
    end

    // Playback reads pattern_q, so a same-cycle write only shows on the next visit.
    always_comb begin
        pattern_d = pattern_q;
        if (Clear) begin
            pattern_d = '0;
        end else if (WrEn) begin
            for (int t = 0; t < TRACKS; t++) begin
                for (int s = 0; s < STEPS; s++) begin
                    if (WrTrack == 2'(t) && WrStep == 4'(s)) begin
                        pattern_d[t][s] = WrData;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cur_step_q <= '0;
            trig_q     <= '0;
            gate_q     <= '0;
            beat_q     <= 1'b0;
            running_q  <= 1'b0;
            pattern_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_step_q <= cur_step_d;
            trig_q     <= trig_d;
            gate_q     <= gate_d;
            beat_q     <= beat_d;
            running_q  <= running_d;
            pattern_q  <= pattern_d;
        end
    end

    assign CurStep = cur_step_q;
    assign Trig    = trig_q;
    assign Beat    = beat_q;
    assign Running = running_q;

endmodule

// File: tb/tb_step_player.sv
// Bench for step_player: fixed vector table, directed scenarios and random
// traffic checked against an event-level model of the sequencer.
module tb_step_player;

    localparam int TRACKS = 4;
    localparam int STEPS  = 16;
    localparam int GATE_W = 8;

    logic              Clock   = 1'b0;
    logic              nReset  = 1'b0;
    logic              Step    = 1'b0;
    logic              Play    = 1'b0;
    logic              Clear   = 1'b0;
    logic              WrEn    = 1'b0;
    logic [1:0]        WrTrack = '0;
    logic [3:0]        WrStep  = '0;
    logic              WrData  = 1'b0;
    logic [4:0]        Length  = 5'd16;
    logic [GATE_W-1:0] GateLen = 8'd1;
    logic [3:0]        CurStep;
    logic [TRACKS-1:0] Trig;
    logic              Running;
    logic              Beat;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_trig0 = 0;
    int cnt_beat  = 0;

    always #5 Clock = ~Clock;

    step_player #(.TRACKS(TRACKS), .STEPS(STEPS), .GATE_W(GATE_W)) dut (
        .Clock(Clock), .nReset(nReset), .Step(Step), .Play(Play), .Clear(Clear),
        .WrEn(WrEn), .WrTrack(WrTrack), .WrStep(WrStep), .WrData(WrData),
        .Length(Length), .GateLen(GateLen), .CurStep(CurStep), .Trig(Trig),
        .Running(Running), .Beat(Beat)
    );

    // Model: trigger column of the last fired step stays visible for gl cycles.
    bit                m_play;
    int                m_ptr, m_cur, m_since, m_gl;
    bit                m_beat, m_active;
    bit [TRACKS-1:0]   m_col;
    bit                m_pat [TRACKS][STEPS];

    task automatic model_reset();
        m_play = 0; m_ptr = 0; m_cur = 0; m_since = 0; m_gl = 1;
        m_beat = 0; m_active = 0; m_col = '0;
        for (int t = 0; t < TRACKS; t++)
            for (int s = 0; s < STEPS; s++) m_pat[t][s] = 0;
    endtask

    task automatic model_edge();
        int eff, idx;
        if (!nReset) begin
            model_reset();
            return;
        end
        m_beat = 0;
        if (m_play) begin
            if (!Play) begin
                m_play = 0; m_ptr = 0; m_cur = 0; m_active = 0;
            end else if (Step) begin
                eff = (Length == 0 || Length > 16) ? 16 : int'(Length);
                idx = (m_ptr >= eff) ? 0 : m_ptr;
                for (int t = 0; t < TRACKS; t++) m_col[t] = m_pat[t][idx];
                m_cur = idx;
                m_beat = (idx == 0);
                m_since = 0;
                m_gl = (GateLen == 0) ? 1 : int'(GateLen);
                m_active = 1;
                m_ptr = (idx + 1 >= eff) ? 0 : idx + 1;
            end else if (m_active) begin
                m_since++;
                if (m_since >= m_gl) m_active = 0;
            end
        end else if (Play) begin
            m_play = 1;
        end
        if (Clear) begin
            for (int t = 0; t < TRACKS; t++)
                for (int s = 0; s < STEPS; s++) m_pat[t][s] = 0;
        end else if (WrEn && int'(WrTrack) < TRACKS) begin
            m_pat[WrTrack][WrStep] = WrData;
        end
    endtask

    task automatic check(string name);
        logic [TRACKS-1:0] exp_trig;
        exp_trig = m_active ? m_col : '0;
        n_tests++;
        if (Trig !== exp_trig || CurStep !== 4'(m_cur) || Beat !== m_beat || Running !== m_play) begin
            n_fail++;
            $display("FAIL %s t=%0t: got trig=%h cur=%0d beat=%b run=%b, want trig=%h cur=%0d beat=%b run=%b",
                     name, $time, Trig, CurStep, Beat, Running, exp_trig, m_cur, m_beat, m_play);
        end
    endtask

    task automatic expect_val(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick(string name);
        model_edge();
        @(posedge Clock);
        #1;
        check(name);
        if (Trig[0]) cnt_trig0++;
        if (Beat) cnt_beat++;
    endtask

    task automatic pulse(string name);
        Step = 1'b1; tick(name); Step = 1'b0;
        tick(name); tick(name);
    endtask

    task automatic quiet_inputs();
        Step = 0; Clear = 0; WrEn = 0; WrTrack = 0; WrStep = 0; WrData = 0;
    endtask

    typedef struct {
        logic       step, play, clear, wren;
        logic [1:0] trk;
        logic [3:0] stp;
        logic       dat;
        logic [4:0] len;
        logic [7:0] gl;
        logic [3:0] e_trig, e_cur;
        logic       e_beat, e_run;
    } vec_t;

    vec_t vecs [13];
    int   expect_cur [7];

    initial begin
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,4'd0,1'b1,5'd16,8'd1, 4'h0,4'd0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'd1,1'b1,5'd16,8'd1, 4'h0,4'd0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd2, 4'h0,4'd0,1'b0,1'b1};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd2, 4'h1,4'd0,1'b1,1'b1};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd2, 4'h1,4'd0,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd2, 4'h0,4'd0,1'b0,1'b1};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd0, 4'h4,4'd1,1'b0,1'b1};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd0, 4'h0,4'd1,1'b0,1'b1};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd2, 8'd5, 4'h1,4'd0,1'b1,1'b1};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,1'b0,5'd2, 8'd5, 4'h0,4'd0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,2'd1,4'd1,1'b1,5'd16,8'd1, 4'h0,4'd0,1'b0,1'b1};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd1, 4'h0,4'd0,1'b1,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,2'd0,4'd0,1'b0,5'd16,8'd1, 4'h0,4'd1,1'b0,1'b1};

        // Reset state.
        #3;
        n_tests++;
        if (Trig !== 4'h0 || CurStep !== 4'd0 || Beat !== 1'b0 || Running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got trig=%h cur=%0d beat=%b run=%b, want all 0",
                     Trig, CurStep, Beat, Running);
        end
        @(posedge Clock); #1;
        nReset = 1'b1;

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            Step = vecs[i].step; Play = vecs[i].play; Clear = vecs[i].clear;
            WrEn = vecs[i].wren; WrTrack = vecs[i].trk; WrStep = vecs[i].stp;
            WrData = vecs[i].dat; Length = vecs[i].len; GateLen = vecs[i].gl;
            @(posedge Clock); #1;
            n_tests++;
            if (Trig !== vecs[i].e_trig || CurStep !== vecs[i].e_cur ||
                Beat !== vecs[i].e_beat || Running !== vecs[i].e_run) begin
                n_fail++;
                $display("FAIL vec%0d: got trig=%h cur=%0d beat=%b run=%b, want trig=%h cur=%0d beat=%b run=%b",
                         i, Trig, CurStep, Beat, Running,
                         vecs[i].e_trig, vecs[i].e_cur, vecs[i].e_beat, vecs[i].e_run);
            end
        end

        quiet_inputs();
        Play = 0;
        nReset = 1'b0;
        #1;
        model_reset();
        tick("reset_hold");
        nReset = 1'b1;
        tick("idle");

        // Four-on-the-floor on track 0.
        Length = 16; GateLen = 3;
        for (int s = 0; s < STEPS; s++) begin
            WrEn = 1; WrTrack = 0; WrStep = 4'(s); WrData = (s % 4 == 0);
            tick("wr036");
        end
        quiet_inputs();
        Play = 1;
        tick("start036");
        cnt_trig0 = 0; cnt_beat = 0;
        for (int p = 0; p < 16; p++) begin
            Step = 1; tick("r036"); Step = 0;
            repeat (99) tick("r036");
        end
        expect_val("r036_trig0_cycles", cnt_trig0, 12);
        expect_val("r036_beats", cnt_beat, 1);

        // Short loop.
        expect_cur = '{0, 1, 2, 0, 1, 2, 0};
        Length = 3; GateLen = 1;
        for (int p = 0; p < 7; p++) begin
            Step = 1; tick("r037"); Step = 0;
            expect_val($sformatf("r037_cur%0d", p), int'(CurStep), expect_cur[p]);
            expect_val($sformatf("r037_beat%0d", p), int'(Beat), (p % 3 == 0) ? 1 : 0);
            tick("r037"); tick("r037");
        end

        // Overlapping gates with a full pattern.
        Length = 16; GateLen = 10;
        for (int t = 0; t < TRACKS; t++)
            for (int s = 0; s < STEPS; s++) begin
                WrEn = 1; WrTrack = 2'(t); WrStep = 4'(s); WrData = 1;
                tick("wr038");
            end
        quiet_inputs();
        Step = 1; tick("r038"); Step = 0;
        begin
            int low_cycles;
            low_cycles = (Trig !== 4'hF) ? 1 : 0;
            for (int p = 0; p < 10; p++) begin
                repeat (3) begin
                    tick("r038");
                    if (Trig !== 4'hF) low_cycles++;
                end
                Step = 1; tick("r038"); Step = 0;
                if (Trig !== 4'hF) low_cycles++;
            end
            expect_val("r038_low_cycles", low_cycles, 0);
        end
        repeat (12) tick("r038_tail");

        // Write/fire collision, then Clear beating WrEn.
        Clear = 1; tick("clr039"); Clear = 0;
        GateLen = 2;
        Play = 0; tick("r039"); Play = 1; tick("r039");
        pulse("r039"); pulse("r039");
        Step = 1; WrEn = 1; WrTrack = 1; WrStep = 2; WrData = 1;
        tick("r039_collide");
        quiet_inputs();
        expect_val("r039_old_value", int'(Trig[1]), 0);
        expect_val("r039_old_cur", int'(CurStep), 2);
        tick("r039"); tick("r039");
        repeat (15) pulse("r039");
        Step = 1; tick("r039_next"); Step = 0;
        expect_val("r039_new_value", int'(Trig[1]), 1);
        Clear = 1; WrEn = 1; WrTrack = 0; WrStep = 0; WrData = 1;
        tick("r039_clrwr");
        quiet_inputs();
        Play = 0; tick("r039"); Play = 1; tick("r039");
        Step = 1; tick("r039_after_clr"); Step = 0;
        expect_val("r039_clr_prio", int'(Trig), 0);
        expect_val("r039_clr_beat", int'(Beat), 1);
        repeat (15) pulse("r039_sweep");

        // Stop mid-gate, restart, async reset mid-gate.
        GateLen = 8;
        Play = 0; tick("r040");
        WrEn = 1; WrTrack = 3; WrStep = 0; WrData = 1; tick("r040"); quiet_inputs();
        Play = 1; tick("r040");
        Step = 1; tick("r040"); Step = 0;
        tick("r040");
        Play = 0; tick("r040_stop");
        expect_val("r040_stop_trig", int'(Trig), 0);
        expect_val("r040_stop_run", int'(Running), 0);
        Play = 1; tick("r040");
        Step = 1; tick("r040_restart"); Step = 0;
        expect_val("r040_restart_cur", int'(CurStep), 0);
        expect_val("r040_restart_beat", int'(Beat), 1);
        expect_val("r040_restart_trig", int'(Trig), 8);
        tick("r040");
        #2 nReset = 1'b0;
        #1;
        expect_val("r040_async_trig", int'(Trig), 0);
        expect_val("r040_async_run", int'(Running), 0);
        model_reset();
        Play = 0;
        tick("r040_in_reset");
        nReset = 1'b1;
        tick("r040_out");

        // Random traffic.
        Play = 1; Length = 16; GateLen = 2;
        for (int c = 0; c < 3000; c++) begin
            Step    = ($urandom_range(0, 3) == 0);
            Clear   = ($urandom_range(0, 63) == 0);
            WrEn    = ($urandom_range(0, 2) == 0);
            WrTrack = 2'($urandom_range(0, 3));
            WrStep  = 4'($urandom_range(0, 15));
            WrData  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) Play = ~Play;
            if ($urandom_range(0, 49) == 0) Length = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) GateLen = 8'($urandom_range(0, 6));
            tick("rand");
        end
        quiet_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
